// File: rtl/as_serial_nb.sv
// Digit-serial adder/subtractor: SLICE bits per cycle, LSB slice first, N=WIDTH/SLICE run cycles.
// Latency N+1 cycles from accepted start to the one-cycle done pulse; start is ignored while busy.
module as_serial_nb #(
   parameter int WIDTH = 8,
   parameter int SLICE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             mode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int N     = WIDTH / SLICE;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
      $error("as_serial_nb: WIDTH must be >= 2 and an exact multiple of SLICE");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               carry_out_q, carry_out_d;
   logic               overflow_q, overflow_d;

   logic               accept;
   logic               last;
   logic [SLICE-1:0]   a_sl;
   logic [SLICE-1:0]   b_sl;
   logic [SLICE:0]     slice_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         result_q    <= result_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
      end
   end

   assign accept = start && (state_q == IDLE || state_q == DONE);
   assign last   = (idx_q == IDX_W'(N - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (last)   state_d = DONE;
         DONE:    state_d = accept ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      result_d    = result_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;

      a_sl      = a_q[idx_q*SLICE +: SLICE];
      b_sl      = b_q[idx_q*SLICE +: SLICE];
      slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(carry_q);

      if (accept) begin
         // Subtraction stores ~B; the +1 enters through the preset carry.
         a_d     = A;
         b_d     = mode ? ~B : B;
         sum_d   = '0;
         idx_d   = '0;
         carry_d = mode;
      end else if (state_q == RUN) begin
         sum_d[idx_q*SLICE +: SLICE] = slice_sum[SLICE-1:0];
         carry_d = slice_sum[SLICE];
         if (last) begin
            result_d    = sum_d;
            carry_out_d = slice_sum[SLICE];
            // carry into the MSB recovered as a ^ b ^ sum at that bit
            overflow_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_d[WIDTH-1] ^ slice_sum[SLICE];
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   always_comb begin
      busy      = (state_q == RUN);
      done      = (state_q == DONE);
      result    = result_q;
      carry_out = carry_out_q;
      overflow  = overflow_q;
   end

endmodule

// File: tb/tb_as_serial_nb.sv
// Directed bench for as_serial_nb at WIDTH=8, SLICE=2 with hand-computed results.
module tb_as_serial_nb;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic       mode;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       carry_out;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   as_serial_nb #(.WIDTH(8), .SLICE(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .A         (a_in),
      .B         (b_in),
      .mode      (mode),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one edge; observe outputs 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"},   busy, 0);
      check({tag, " done"},   done, 0);
      check({tag, " result"}, result, 0);
      check({tag, " cout"},   carry_out, 0);
      check({tag, " ovf"},    overflow, 0);
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic m, input logic [7:0] er, input logic ec, input logic ev);
      start = 1'b1; a_in = a; b_in = b; mode = m;
      step();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         check({tag, " busy"}, busy, 1);
         check({tag, " no done"}, done, 0);
         step();
      end
      check({tag, " done"},   done, 1);
      check({tag, " busy lo"}, busy, 0);
      check({tag, " result"}, result, er);
      check({tag, " cout"},   carry_out, ec);
      check({tag, " ovf"},    overflow, ev);
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; a_in = 8'd9; b_in = 8'd9; mode = 1'b0;
      step();
      step();
      check_all_zero("reset");
      start = 1'b0;
      rst = 1'b0;
      step();
      check("idle busy", busy, 0);

      run_op("3+5",     8'd3,   8'd5,   1'b0, 8'd8,   1'b0, 1'b0);
      run_op("200+100", 8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0);
      run_op("127+1",   8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1);
      run_op("5-3",     8'd5,   8'd3,   1'b1, 8'd2,   1'b1, 1'b0);
      run_op("3-5",     8'd3,   8'd5,   1'b1, 8'd254, 1'b0, 1'b0);
      run_op("128-1",   8'd128, 8'd1,   1'b1, 8'd127, 1'b1, 1'b1);

      // Outputs hold in IDLE.
      step();
      check("hold idle done", done, 0);
      check("hold idle result", result, 127);
      check("hold idle ovf", overflow, 1);

      // Start and operand changes during RUN are ignored.
      start = 1'b1; a_in = 8'd12; b_in = 8'd3; mode = 1'b0;
      step();
      a_in = 8'd1; b_in = 8'd1;
      for (int k = 1; k <= 4; k++) begin
         if (k == 4) start = 1'b0;
         check("ign busy", busy, 1);
         check("ign no done", done, 0);
         step();
      end
      check("ign done", done, 1);
      check("ign result", result, 15);
      check("ign cout", carry_out, 0);

      // Back-to-back start issued during the DONE cycle.
      start = 1'b1; a_in = 8'd100; b_in = 8'd27; mode = 1'b0;
      step();
      start = 1'b0;
      check("b2b busy", busy, 1);
      check("b2b no done", done, 0);
      step();
      check("b2b hold result", result, 15);
      step();
      step();
      check("b2b still busy", busy, 1);
      step();
      check("b2b done", done, 1);
      check("b2b result", result, 127);
      step();
      check("b2b single done", done, 0);
      check("b2b to idle", busy, 0);

      // Reset asserted in the second RUN cycle aborts the operation.
      start = 1'b1; a_in = 8'd50; b_in = 8'd20; mode = 1'b0;
      step();
      start = 1'b0;
      step();
      check("abort in run", busy, 1);
      rst = 1'b1;
      step();
      check_all_zero("abort");
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check("abort no done", done, 0);
         check("abort idle", busy, 0);
      end

      run_op("8-6", 8'd8, 8'd6, 1'b1, 8'd2, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
